// File: rtl/tone_sequencer.sv
// Plays a programmable table of notes by driving a square-wave generator's enable and prescaler.
// Each note is followed by a one-unit silent gap. A prescaler of 16'hFFFF marks a rest.
module tone_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [15:0]              wr_prescaler,
  input  logic [11:0]              wr_dur,
  input  logic [$clog2(DEPTH)-1:0] seq_last,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     wave_ena,
  output logic [15:0]              wave_prescaler
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = 12 + $clog2(TICK_DIV);
  localparam logic [15:0] REST = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_q, last_d;
  logic          loop_q, loop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ena_q, ena_d;
  logic [15:0]   presc_q, presc_d;

  logic [15:0]   presc_mem [DEPTH];
  logic [11:0]   dur_mem   [DEPTH];
  logic [11:0]   dur_eff;
  logic [CW-1:0] play_len;

  // Note table has no reset; it can only be rewritten while idle.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      presc_mem[wr_addr] <= wr_prescaler;
      dur_mem[wr_addr]   <= wr_dur;
    end
  end

  always_comb begin
    dur_eff  = (dur_mem[idx_q] == 12'd0) ? 12'd1 : dur_mem[idx_q];
    play_len = CW'(dur_eff) * CW'(TICK_DIV) - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    ena_d   = 1'b0;
    presc_d = presc_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          last_d  = seq_last;
          loop_d  = loop;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        presc_d = presc_mem[idx_q];
        cnt_d   = play_len;
        ena_d   = (presc_mem[idx_q] != REST);
        state_d = PLAY;
      end
      PLAY: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(TICK_DIV - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
          ena_d = (presc_q != REST);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (idx_q < last_q) begin
            idx_d   = idx_q + AW'(1);
            state_d = LOAD;
          end else if (loop_q) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything and silences the output without a done pulse.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = idx_q;
      presc_d = presc_q;
      ena_d   = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ena_q   <= ena_d;
      presc_q <= presc_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign note_idx       = idx_q;
  assign wave_ena       = ena_q;
  assign wave_prescaler = presc_q;

endmodule
